// File: rtl/dart_pkg.sv
// Shared types and screen constants for the dart pool controller.
package dart_pkg;

  typedef struct packed {
    logic       valid;
    logic [9:0] x;
    logic [9:0] y;
    logic       dir;
  } dart_slot_t;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    ALLOC
  } state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Widened to 11 bits so a box near the right/bottom edge never wraps.
  function automatic logic in_span(input logic [9:0] pos, input logic [9:0] lo,
                                   input logic [10:0] len);
    logic [10:0] p;
    logic [10:0] l;
    p = {1'b0, pos};
    l = {1'b0, lo};
    return (p >= l) && (p < l + len);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int i = 0; i < N; i++) begin
      cand = (int'(ptr) + i) % N;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/dart_pool_ctrl.sv
// Dart slot pool: per-frame move/retire, round-robin launch, per-pixel hit test.
// Optional per-shooter fire cooldown enabled by defining DART_COOLDOWN_EN.
module dart_pool_ctrl
  import dart_pkg::*;
#(
  parameter int NUM_SLOTS       = 4,
  parameter int NUM_SHOOTERS    = 2,
  parameter int DART_SPEED      = 4,
  parameter int DART_W          = 8,
  parameter int DART_H          = 2,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      frame_clk,
  input  logic [NUM_SHOOTERS-1:0]   fire_req,
  input  logic [10*NUM_SHOOTERS-1:0] fire_x,
  input  logic [10*NUM_SHOOTERS-1:0] fire_y,
  input  logic [NUM_SHOOTERS-1:0]   fire_dir,
  output logic [NUM_SHOOTERS-1:0]   fire_gnt,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  output logic [6:0]                is_dart,
  output logic                      busy
);

  localparam int SW = $clog2(NUM_SLOTS);
  localparam int IW = (NUM_SHOOTERS > 1) ? $clog2(NUM_SHOOTERS) : 1;
  localparam logic [10:0] SPEED11     = 11'(DART_SPEED);
  localparam logic [9:0]  SPEED10     = 10'(DART_SPEED);
  localparam logic [10:0] RIGHT_LIMIT = 11'(SCREEN_W - 1 - DART_W);

  logic       frame_clk_q, frame_clk_d;
  state_t     state_q, state_d;
  logic [SW-1:0] slot_idx_q, slot_idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  dart_slot_t slots_q [NUM_SLOTS];
  dart_slot_t slots_d [NUM_SLOTS];

  logic                    frame_edge;
  logic [NUM_SHOOTERS-1:0] elig;
  logic [NUM_SHOOTERS-1:0] arb_gnt;
  logic [IW-1:0]           arb_idx;
  logic                    arb_any;
  logic                    free_any;
  logic [SW-1:0]           free_idx;
  logic                    grant_ok;

  assign frame_edge  = frame_clk & ~frame_clk_q;
  assign frame_clk_d = frame_clk;
  assign busy        = (state_q != IDLE);

`ifdef DART_COOLDOWN_EN
  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN_FRAMES);
  logic [CW-1:0] cd_q [NUM_SHOOTERS];
  logic [CW-1:0] cd_d [NUM_SHOOTERS];

  always_comb begin
    for (int i = 0; i < NUM_SHOOTERS; i++) begin
      elig[i] = fire_req[i] && (cd_q[i] == '0);
    end
  end

  // Counters tick after eligibility is sampled, giving COOLDOWN_FRAMES fully blocked frames.
  always_comb begin
    for (int i = 0; i < NUM_SHOOTERS; i++) begin
      cd_d[i] = cd_q[i];
      if (state_q == ALLOC) begin
        if (grant_ok && arb_gnt[i]) begin
          cd_d[i] = CD_LOAD;
        end else if (cd_q[i] != '0) begin
          cd_d[i] = cd_q[i] - 1'b1;
        end
      end
    end
  end
`else
  assign elig = fire_req;
`endif

  rr_arbiter #(.N(NUM_SHOOTERS)) u_arb (
    .req (elig),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (!free_any && !slots_q[k].valid) begin
        free_any = 1'b1;
        free_idx = SW'(k);
      end
    end
  end

  assign grant_ok = (state_q == ALLOC) && arb_any && free_any;
  assign fire_gnt = grant_ok ? arb_gnt : '0;

  always_comb begin
    state_d    = state_q;
    slot_idx_d = slot_idx_q;
    ptr_d      = ptr_q;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      slots_d[k] = slots_q[k];
    end
    case (state_q)
      IDLE: begin
        if (frame_edge) begin
          state_d    = UPDATE;
          slot_idx_d = '0;
        end
      end
      UPDATE: begin
        for (int k = 0; k < NUM_SLOTS; k++) begin
          if (SW'(k) == slot_idx_q && slots_q[k].valid) begin
            if (slots_q[k].dir) begin
              if ({1'b0, slots_q[k].x} + SPEED11 > RIGHT_LIMIT) begin
                slots_d[k].valid = 1'b0;
              end else begin
                slots_d[k].x = slots_q[k].x + SPEED10;
              end
            end else begin
              if (slots_q[k].x < SPEED10) begin
                slots_d[k].valid = 1'b0;
              end else begin
                slots_d[k].x = slots_q[k].x - SPEED10;
              end
            end
          end
        end
        if (slot_idx_q == SW'(NUM_SLOTS - 1)) begin
          state_d = ALLOC;
        end else begin
          slot_idx_d = slot_idx_q + 1'b1;
        end
      end
      ALLOC: begin
        if (grant_ok) begin
          for (int k = 0; k < NUM_SLOTS; k++) begin
            if (SW'(k) == free_idx) begin
              slots_d[k].valid = 1'b1;
              slots_d[k].x     = fire_x[int'(arb_idx)*10 +: 10];
              slots_d[k].y     = fire_y[int'(arb_idx)*10 +: 10];
              slots_d[k].dir   = fire_dir[arb_idx];
            end
          end
          ptr_d = (int'(arb_idx) == NUM_SHOOTERS - 1) ? '0 : arb_idx + 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_clk_q <= 1'b0;
      state_q     <= IDLE;
      slot_idx_q  <= '0;
      ptr_q       <= '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        slots_q[k] <= '0;
      end
`ifdef DART_COOLDOWN_EN
      for (int i = 0; i < NUM_SHOOTERS; i++) begin
        cd_q[i] <= '0;
      end
`endif
    end else begin
      frame_clk_q <= frame_clk_d;
      state_q     <= state_d;
      slot_idx_q  <= slot_idx_d;
      ptr_q       <= ptr_d;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        slots_q[k] <= slots_d[k];
      end
`ifdef DART_COOLDOWN_EN
      for (int i = 0; i < NUM_SHOOTERS; i++) begin
        cd_q[i] <= cd_d[i];
      end
`endif
    end
  end

  // Lowest-index hitting slot wins so the mapper sees a stable index on overlaps.
  logic       hit;
  logic [2:0] hit_idx;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (!hit && slots_q[k].valid &&
          in_span(DrawX, slots_q[k].x, 11'(DART_W)) &&
          in_span(DrawY, slots_q[k].y, 11'(DART_H))) begin
        hit     = 1'b1;
        hit_idx = 3'(k);
      end
    end
  end

  assign is_dart = {3'b000, hit_idx, hit};

endmodule
